// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: state encoding and instruction field constants shared by the fetch unit
package instruction_fetch_pkg;
  localparam int INSTR_W = 8;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_READ      = 3'd1;
  localparam state_t S_CAPTURE   = 3'd2;
  localparam state_t S_LOAD      = 3'd3;
  localparam state_t S_WAIT_NEXT = 3'd4;
  localparam int MNEM_HI = 7;
  localparam int MNEM_LO = 6;
  localparam int LSB_HI  = 5;
  localparam int LSB_LO  = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;
endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// instruction_fetch_pc_counter: program counter with reset load, wrapping increment and branch load
// ports: clk, rst, inc (advance by one), load/load_addr (branch target, wins over inc), pc
module instruction_fetch_pc_counter #(
  parameter int ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    pc <= rst ? RST_PC : load ? load_addr : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads instructions from a synchronous ROM and hands them to the IR with an ena/ack handshake
// ports: clk, rst | start, halt, next_req, branch_valid, branch_addr (execute side)
//        mem_rd_en, mem_addr, mem_data (ROM) | ir_data, ir_ena, ir_ack (IR) | pc, busy, fetch_err (status)
// FETCH_ACK_TIMEOUT_EN: when defined, LOAD gives up after ACK_TIMEOUT cycles without ack and sets fetch_err
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter logic [ADDR_W-1:0] RST_PC = '0,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               next_req,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_ena,
  input  logic               ir_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_err
);
  state_t st;
  logic to_hit;
  assign mem_rd_en = st == S_READ;
  assign mem_addr  = pc;
  assign ir_ena    = st == S_LOAD;
  assign busy      = st != S_IDLE;
  instruction_fetch_pc_counter #(.ADDR_W(ADDR_W), .RST_PC(RST_PC)) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (st == S_CAPTURE),
    .load     (st == S_WAIT_NEXT && !halt && branch_valid),
    .load_addr(branch_addr),
    .pc       (pc)
  );
`ifdef FETCH_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  // counter is held at zero outside LOAD, so every LOAD entry starts fresh
  assign to_hit = st == S_LOAD && !ir_ack && to_cnt == TW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      to_cnt    <= st == S_LOAD ? to_cnt + 1'b1 : '0;
      fetch_err <= to_hit | (fetch_err & !(st == S_IDLE && start));
    end
`else
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      st      <= S_IDLE;
      ir_data <= '0;
    end else begin
      if (st == S_CAPTURE) ir_data <= mem_data;
      case (st)
        S_IDLE:      st <= start ? S_READ : S_IDLE;
        S_READ:      st <= S_CAPTURE;
        S_CAPTURE:   st <= S_LOAD;
        S_LOAD:      st <= ir_ack ? S_WAIT_NEXT : to_hit ? S_IDLE : S_LOAD;
        S_WAIT_NEXT: st <= halt ? S_IDLE : (branch_valid || next_req) ? S_READ : S_WAIT_NEXT;
        default:     st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench for instruction_fetch against a PC/ROM reference model
module tb_instruction_fetch;
  logic clk = 0, rst = 1, start = 0, halt = 0, next_req = 0, branch_valid = 0, ir_ack = 0;
  logic [3:0] branch_addr = 0, mem_addr, pc;
  logic mem_rd_en, ir_ena, busy, fetch_err;
  logic [7:0] mem_data = 0, ir_data;
  logic [7:0] rom [16];
  logic [11:0] exp_q [$];
  int n_chk = 0, n_fail = 0;
  int model_pc = 0;
  logic prev_ena = 0;
  logic [7:0] held = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .next_req(next_req),
    .branch_valid(branch_valid), .branch_addr(branch_addr), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .ir_data(ir_data), .ir_ena(ir_ena),
    .ir_ack(ir_ack), .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );

  always @(posedge clk) if (mem_rd_en) mem_data <= rom[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: each new IR load must match the oldest outstanding fetch
  always @(negedge clk) begin
    if (ir_ena && !prev_ena) begin
      if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
      else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("ir_data", ir_data, e[11:4]);
        chk("pc_at_load", pc, e[3:0]);
        held = e[11:4];
      end
    end else if (ir_ena && prev_ena) chk("ir_hold", ir_data, held);
    prev_ena = ir_ena;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input logic on);
    start        = on & $urandom_range(0, 1);
    halt         = on & $urandom_range(0, 1);
    next_req     = on & $urandom_range(0, 1);
    branch_valid = on & $urandom_range(0, 1);
    branch_addr  = 4'($urandom);
  endtask

  // kind 0: start from IDLE, 1: next_req, 2: branch (with next_req) from WAIT_NEXT
  task automatic issue(input int kind, input logic [3:0] baddr);
    int tgt, n;
    tgt = (kind == 2) ? int'(baddr) : model_pc;
    start = kind == 0;
    next_req = kind != 0;
    branch_valid = kind == 2;
    branch_addr = baddr;
    exp_q.push_back({rom[tgt], 4'(tgt + 1)});
    model_pc = (tgt + 1) % 16;
    step();
    noise(0);
    chk("read_strobe", mem_rd_en, 1);
    chk("read_addr", mem_addr, tgt);
    chk("err_clear", fetch_err, 0);
    n = 1;
    while (!ir_ena && n < 8) begin
      noise(1);
      step();
      n++;
    end
    noise(0);
    chk("latency", n, 3);
  endtask

  task automatic ack_it(input int d);
    repeat (d) begin
      noise(1);
      step();
      chk("ena_wait_ack", ir_ena, 1);
    end
    noise(0);
    ir_ack = 1;
    step();
    ir_ack = 0;
    chk("ena_gap", ir_ena, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic stay(input int k);
    repeat (k) begin
      start = $urandom_range(0, 1);
      ir_ack = $urandom_range(0, 1);
      step();
      chk("stay_ena", ir_ena, 0);
      chk("stay_pc", pc, model_pc);
    end
    start = 0;
    ir_ack = 0;
  endtask

  task automatic halt_op();
    halt = 1;
    next_req = 1;
    branch_valid = $urandom_range(0, 1);
    branch_addr = 4'($urandom);
    step();
    noise(0);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, model_pc);
    repeat ($urandom_range(0, 2)) begin
      next_req = $urandom_range(0, 1);
      branch_valid = $urandom_range(0, 1);
      halt = $urandom_range(0, 1);
      step();
      chk("idle_busy", busy, 0);
      chk("idle_pc", pc, model_pc);
    end
    noise(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (rom[i]) rom[i] = 8'($urandom);
    rom[0] = 8'h5A;
    rom[1] = 8'hC3;
    rom[2] = 8'h0F;
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_ir_ena", ir_ena, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", fetch_err, 0);
    rst = 0;
    step();
    chk("idle_busy", busy, 0);
    issue(0, 0); ack_it(1);
    issue(1, 0); ack_it(1);
    issue(1, 0); ack_it(1);
    issue(2, 4'h9); ack_it(2);
    issue(2, 4'hF); ack_it(1);
    issue(1, 0); ack_it(1);
    halt_op();
    issue(0, 0); ack_it(1);
    issue(1, 0);
`ifdef FETCH_ACK_TIMEOUT_EN
    repeat (7) step();
    chk("to_still_load", ir_ena, 1);
    step();
    chk("to_err", fetch_err, 1);
    chk("to_ena", ir_ena, 0);
    chk("to_busy", busy, 0);
    chk("to_pc", pc, model_pc);
    issue(0, 0);
`else
    repeat (20) step();
    chk("noto_ena", ir_ena, 1);
    chk("noto_err", fetch_err, 0);
`endif
    ack_it(0);
    issue(1, 0);
    rst = 1;
    step();
    rst = 0;
    model_pc = 0;
    chk("midrst_ena", ir_ena, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_ir", ir_data, 0);
    chk("midrst_busy", busy, 0);
    issue(0, 0); ack_it(1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: issue(1, 0);
        1: issue(2, 4'($urandom));
        2: begin halt_op(); issue(0, 0); end
        default: begin stay($urandom_range(1, 3)); issue(1, 0); end
      endcase
      ack_it($urandom_range(1, 4));
    end
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
